// File: rtl/grid_pixel_gen.sv
// grid_pixel_gen: two-stage pixel colour generator for a GRID_N x GRID_N
// number board with glyphs, cursor fill, thick block lines and a status border.
// Ports: clk, rst (async, active high), video_on, pixel_x/pixel_y (10b),
//        board (GRID_N*GRID_N nibbles, cell (0,0) in MSBs), cur_row/cur_col/
//        cur_valid (cursor), status (01 won, 10 lost), r/g/b (registered
//        4b each), frame_tick (registered one-clock pulse per frame).
// Option: define GRID_CURSOR_BLINK_EN to blink the cursor fill on frame bit 5.
module grid_pixel_gen #(
    parameter int          GRID_N   = 9,
    parameter int          SUB      = 3,
    parameter int          CELL_PX  = 40,
    parameter int          ORIGIN_X = 60,
    parameter int          ORIGIN_Y = 40,
    parameter logic [11:0] BG_COLOR = 12'hEEE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       video_on,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic [GRID_N*GRID_N*4-1:0] board,
    input  logic [3:0]                 cur_row,
    input  logic [3:0]                 cur_col,
    input  logic                       cur_valid,
    input  logic [1:0]                 status,
    output logic [3:0]                 r,
    output logic [3:0]                 g,
    output logic [3:0]                 b,
    output logic                       frame_tick
);

    localparam int OW     = $clog2(CELL_PX);
    localparam int NCELL  = GRID_N * GRID_N;
    // Grid spans GRID_N pitches plus the 2 px closing edge.
    localparam int GRID_W = GRID_N * CELL_PX + 2;
    // 15x21 glyph box centred in the interior (offsets 1..CELL_PX-1).
    localparam int GX0    = 1 + (CELL_PX - 16) / 2;
    localparam int GY0    = 1 + (CELL_PX - 22) / 2;

    localparam logic [10:0] X0 = 11'(ORIGIN_X);
    localparam logic [10:0] Y0 = 11'(ORIGIN_Y);
    localparam logic [10:0] GW = 11'(GRID_W);
    localparam logic [10:0] BW = 11'(GRID_W - 4);
    localparam logic [3:0]  NQ = 4'(GRID_N);

    typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;

    function automatic logic [2:0] div3(input logic [OW-1:0] d);
        logic [2:0] q;
        q = '0;
        for (int k = 1; k < 7; k++)
            if (d >= OW'(3 * k)) q = 3'(k);
        return q;
    endfunction

    // 5x7 digit font, row 0 in the MSBs, leftmost column as the row MSB.
    function automatic logic [34:0] font(input logic [3:0] v);
        case (v)
            4'd1:    return 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2:    return 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3:    return 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4:    return 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5:    return 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6:    return 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7:    return 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8:    return 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9:    return 35'b01110_10001_10001_01111_00001_00010_01100;
            default: return '0;
        endcase
    endfunction

    // ---------------- stage 1 ----------------
    logic [10:0]   dx, dy;
    logic          on_grid_d, border_d;
    logic [3:0]    row_d, col_d;
    logic [OW-1:0] offx_d, offy_d;

    logic          vid_q, on_grid_q, border_q;
    logic [3:0]    row_q, col_q;
    logic [OW-1:0] offx_q, offy_q;

    assign dx = {1'b0, pixel_x} - X0;
    assign dy = {1'b0, pixel_y} - Y0;

    always_comb begin
        on_grid_d = ({1'b0, pixel_x} >= X0) && (dx < GW) &&
                    ({1'b0, pixel_y} >= Y0) && (dy < GW);
        border_d  = (dx < 11'd4) || (dx >= BW) ||
                    (dy < 11'd4) || (dy >= BW);
        col_d  = '0;
        offx_d = '0;
        row_d  = '0;
        offy_d = '0;
        // Compare against constant cell starts instead of dividing;
        // index GRID_N is the closing edge line.
        for (int c = 0; c <= GRID_N; c++) begin
            if (dx >= 11'(c * CELL_PX)) begin
                col_d  = 4'(c);
                offx_d = OW'(dx - 11'(c * CELL_PX));
            end
            if (dy >= 11'(c * CELL_PX)) begin
                row_d  = 4'(c);
                offy_d = OW'(dy - 11'(c * CELL_PX));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_q     <= 1'b0;
            on_grid_q <= 1'b0;
            border_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            offx_q    <= '0;
            offy_q    <= '0;
        end else begin
            vid_q     <= video_on;
            on_grid_q <= on_grid_d;
            border_q  <= border_d;
            row_q     <= row_d;
            col_q     <= col_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
        end
    end

    // ---------------- frame / status ----------------
    logic       ftick_q;
    logic [5:0] fcnt_q;
    state_t     state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftick_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            ftick_q <= (pixel_y == 10'd481) && (pixel_x == 10'd0);
            if (ftick_q) fcnt_q <= fcnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PLAY;
        end else if (ftick_q) begin
            unique case (status)
                2'b01:   state_q <= WIN;
                2'b10:   state_q <= LOSE;
                default: state_q <= PLAY;
            endcase
        end
    end

    // ---------------- stage 2 ----------------
    logic          thick_x, thick_y, line;
    logic          in_cell, in_box, glyph, fill, cur_hit, cur_show;
    logic [7:0]    idx;
    logic [3:0]    val;
    logic [OW-1:0] gdx, gdy;
    logic [2:0]    gc, gr;
    logic [34:0]   fbits;
    logic [4:0]    rowbits;
    logic [11:0]   border_col, rgb_d, rgb_q;

    always_comb begin
        thick_x = 1'b0;
        thick_y = 1'b0;
        for (int c = 0; c <= GRID_N; c += SUB) begin
            if (col_q == 4'(c)) thick_x = 1'b1;
            if (row_q == 4'(c)) thick_y = 1'b1;
        end
        line = (offx_q == '0) || (thick_x && offx_q == OW'(1)) ||
               (offy_q == '0) || (thick_y && offy_q == OW'(1));

        in_cell = (row_q < NQ) && (col_q < NQ);
        idx     = 8'(row_q) * 8'(GRID_N) + 8'(col_q);
        val     = '0;
        for (int i = 0; i < NCELL; i++)
            if (idx == 8'(i)) val = board[(NCELL - 1 - i) * 4 +: 4];
        if (!in_cell) val = '0;

        gdx    = offx_q - OW'(GX0);
        gdy    = offy_q - OW'(GY0);
        in_box = (offx_q >= OW'(GX0)) && (offx_q < OW'(GX0 + 15)) &&
                 (offy_q >= OW'(GY0)) && (offy_q < OW'(GY0 + 21));
        gc     = div3(gdx);
        gr     = div3(gdy);
        fbits  = font(val);
        rowbits = '0;
        for (int k = 0; k < 7; k++)
            if (gr == 3'(k)) rowbits = fbits[34 - 5 * k -: 5];
        glyph = 1'b0;
        for (int k = 0; k < 5; k++)
            if (gc == 3'(k)) glyph = in_box && rowbits[4 - k];

        fill    = in_cell && (val >= 4'd10);
        cur_hit = cur_valid && (cur_row < NQ) && (cur_col < NQ) &&
                  (row_q == cur_row) && (col_q == cur_col);
`ifdef GRID_CURSOR_BLINK_EN
        cur_show = cur_hit && !fcnt_q[5];
`else
        cur_show = cur_hit;
`endif

        unique case (state_q)
            WIN:     border_col = fcnt_q[4] ? 12'h000 : 12'h0F0;
            LOSE:    border_col = fcnt_q[4] ? 12'h000 : 12'hF00;
            default: border_col = 12'h000;
        endcase

        if (!vid_q)          rgb_d = 12'h000;
        else if (!on_grid_q) rgb_d = BG_COLOR;
        else if (border_q)   rgb_d = border_col;
        else if (line)       rgb_d = 12'h000;
        else if (fill)       rgb_d = 12'hF00;
        else if (glyph)      rgb_d = 12'h008;
        else if (cur_show)   rgb_d = 12'hFF8;
        else                 rgb_d = 12'hFFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_d;
    end

    assign r          = rgb_q[11:8];
    assign g          = rgb_q[7:4];
    assign b          = rgb_q[3:0];
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_grid_pixel_gen.sv
// Directed-vector bench for grid_pixel_gen: 9x9 default instance
// plus a 4x4 (SUB=2) instance sharing the pixel stream.
module tb_grid_pixel_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         video_on;
    logic [9:0]   pixel_x, pixel_y;
    logic [323:0] board9;
    logic [63:0]  board4;
    logic [3:0]   cur_row, cur_col;
    logic         cur_valid;
    logic [1:0]   status;
    logic [3:0]   r9, g9, b9, r4, g4, b4;
    logic         ft9, ft4;
    logic [11:0]  rgb9, rgb4;

    int n_vec = 0;
    int n_bad = 0;

    assign rgb9 = {r9, g9, b9};
    assign rgb4 = {r4, g4, b4};

    always #5 clk = ~clk;

    grid_pixel_gen u9 (
        .clk(clk), .rst(rst), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .board(board9),
        .cur_row(cur_row), .cur_col(cur_col), .cur_valid(cur_valid),
        .status(status), .r(r9), .g(g9), .b(b9), .frame_tick(ft9)
    );

    grid_pixel_gen #(.GRID_N(4), .SUB(2)) u4 (
        .clk(clk), .rst(rst), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .board(board4),
        .cur_row(cur_row), .cur_col(cur_col), .cur_valid(cur_valid),
        .status(status), .r(r4), .g(g4), .b(b4), .frame_tick(ft4)
    );

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Drive one pixel, wait the two pipeline clocks, compare.
    task automatic pix(input string tag, input int x, input int y,
                       input logic v, input bit use4,
                       input logic [11:0] exp);
        @(negedge clk);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, use4 ? rgb4 : rgb9, exp);
    endtask

    // One frame: tick pixel, then the top-left border pixel.
    task automatic tick(input int k, input logic [11:0] exp);
        @(negedge clk);
        pixel_x  = 10'd0;
        pixel_y  = 10'd481;
        video_on = 1'b0;
        @(negedge clk);
        chk($sformatf("ftick_hi_%0d", k), {11'd0, ft9}, 12'd1);
        pixel_x  = 10'd60;
        pixel_y  = 10'd40;
        video_on = 1'b1;
        @(negedge clk);
        chk($sformatf("ftick_lo_%0d", k), {11'd0, ft9}, 12'd0);
        @(posedge clk);
        #1;
        chk($sformatf("border_f%0d", k), rgb9, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] exp;

        rst       = 1'b1;
        video_on  = 1'b1;
        pixel_x   = 10'd0;
        pixel_y   = 10'd481;
        board9    = '0;
        board4    = '0;
        cur_row   = 4'd0;
        cur_col   = 4'd0;
        cur_valid = 1'b0;
        status    = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", rgb9, 12'h000);
        chk("rst_ftick", {11'd0, ft9}, 12'd0);
        pix("rst_grid", 120, 100, 1'b1, 1'b0, 12'h000);
        pix("rst_bg", 10, 10, 1'b1, 1'b0, 12'h000);

        @(negedge clk);
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        rst     = 1'b0;
        @(posedge clk); #1;
        chk("rel_clk1", rgb9, 12'h000);
        @(posedge clk); #1;
        chk("rel_clk2", rgb9, 12'hEEE);
        @(posedge clk); #1;
        chk("rel_clk3", rgb9, 12'hEEE);

        board9[(80 - 0) * 4 +: 4]  = 4'd5;
        board9[(80 - 10) * 4 +: 4] = 4'd12;
        cur_valid = 1'b1;

        pix("corner", 60, 40, 1'b1, 1'b0, 12'h000);
        pix("bg", 10, 10, 1'b1, 1'b0, 12'hEEE);
        pix("vid_off", 120, 100, 1'b0, 1'b0, 12'h000);
        pix("fill12", 120, 100, 1'b1, 1'b0, 12'hF00);

        pix("g5_r0c0", 73, 50, 1'b1, 1'b0, 12'h008);
        pix("g5_r1c1", 76, 53, 1'b1, 1'b0, 12'hFF8);
        pix("g5_r1c0", 73, 53, 1'b1, 1'b0, 12'h008);
        pix("g5_r3c4", 85, 59, 1'b1, 1'b0, 12'h008);
        pix("g5_r3c0", 73, 59, 1'b1, 1'b0, 12'hFF8);
        pix("g5_r6c1", 76, 70, 1'b1, 1'b0, 12'h008);
        pix("g5_r6c0", 73, 70, 1'b1, 1'b0, 12'hFF8);
        pix("g5_left", 72, 50, 1'b1, 1'b0, 12'hFF8);
        pix("g5_right", 88, 50, 1'b1, 1'b0, 12'hFF8);
        pix("g5_above", 73, 49, 1'b1, 1'b0, 12'hFF8);
        pix("g5_below", 76, 71, 1'b1, 1'b0, 12'hFF8);
        pix("cur_int", 68, 48, 1'b1, 1'b0, 12'hFF8);

        pix("thin_c1", 100, 60, 1'b1, 1'b0, 12'h000);
        pix("thin_c1+1", 101, 60, 1'b1, 1'b0, 12'hFFF);
        pix("thick_c3", 180, 60, 1'b1, 1'b0, 12'h000);
        pix("thick_c3+1", 181, 60, 1'b1, 1'b0, 12'h000);
        pix("thick_c3+2", 182, 60, 1'b1, 1'b0, 12'hFFF);
        pix("brd_l3", 63, 205, 1'b1, 1'b0, 12'h000);
        pix("brd_l4", 64, 205, 1'b1, 1'b0, 12'hFFF);
        pix("brd_r357", 417, 205, 1'b1, 1'b0, 12'hFFF);
        pix("brd_r358", 418, 205, 1'b1, 1'b0, 12'h000);
        pix("edge_r", 421, 205, 1'b1, 1'b0, 12'h000);
        pix("off_r", 422, 205, 1'b1, 1'b0, 12'hEEE);

        cur_row = 4'd9;
        cur_col = 4'd2;
        pix("cur92_c82", 160, 380, 1'b1, 1'b0, 12'hFFF);
        pix("cur92_c02", 160, 60, 1'b1, 1'b0, 12'hFFF);
        pix("cur92_c00", 68, 48, 1'b1, 1'b0, 12'hFFF);
        cur_row = 4'd8;
        pix("cur82_c82", 160, 380, 1'b1, 1'b0, 12'hFF8);

        cur_valid = 1'b0;
        pix("n4_thin1", 100, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_thin1+1", 101, 60, 1'b1, 1'b1, 12'hFFF);
        pix("n4_thick2", 140, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_thick2+1", 141, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_thick2+2", 142, 60, 1'b1, 1'b1, 12'hFFF);
        pix("n4_thin3", 180, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_thin3+1", 181, 60, 1'b1, 1'b1, 12'hFFF);
        pix("n4_edge0", 60, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_edge0+1", 61, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_edge4", 220, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_edge4+1", 221, 60, 1'b1, 1'b1, 12'h000);
        pix("n4_off", 222, 60, 1'b1, 1'b1, 12'hEEE);
        pix("n4_in157", 217, 60, 1'b1, 1'b1, 12'hFFF);
        pix("n4_row1", 120, 80, 1'b1, 1'b1, 12'h000);
        pix("n4_row1+1", 120, 81, 1'b1, 1'b1, 12'hFFF);
        pix("n4_row2+1", 120, 121, 1'b1, 1'b1, 12'h000);
        pix("n4_row2+2", 120, 122, 1'b1, 1'b1, 12'hFFF);
        cur_valid = 1'b1;
        cur_row   = 4'd3;
        cur_col   = 4'd3;
        pix("n4_cur33", 200, 180, 1'b1, 1'b1, 12'hFF8);
        cur_row   = 4'd4;
        cur_col   = 4'd0;
        pix("n4_cur40", 80, 180, 1'b1, 1'b1, 12'hFFF);

        pix("pre_arst", 120, 100, 1'b1, 1'b0, 12'hF00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_rgb", rgb9, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        status = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            exp = ((k & 16) != 0) ? 12'h000 : 12'h0F0;
            tick(k, exp);
        end
        status = 2'b00;
        pix("win_hold", 60, 40, 1'b1, 1'b0, 12'h0F0);
        tick(41, 12'h000);
        status = 2'b10;
        tick(42, 12'hF00);
        status = 2'b11;
        tick(43, 12'h000);

        cur_row = 4'd0;
        cur_col = 4'd0;
`ifdef GRID_CURSOR_BLINK_EN
        exp = 12'hFFF;
`else
        exp = 12'hFF8;
`endif
        pix("cur_f43", 68, 48, 1'b1, 1'b0, exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_pixel_gen.md
GRID_PIXEL_GEN -- requirements
Module: grid_pixel_gen

Interface
REQ-001 SHALL have parameter GRID_N, default 9: cells per row/column, legal values 4 and 9.
REQ-002 SHALL have parameter SUB, default 3: cells per thick-line block, equal to sqrt(GRID_N).
REQ-003 SHALL have parameter CELL_PX, default 40: cell pitch in pixels, including the 1 px grid line.
REQ-004 SHALL have parameters ORIGIN_X and ORIGIN_Y, defaults 60 and 40: top-left pixel of the grid.
REQ-005 SHALL have parameter BG_COLOR, default 12'hEEE: colour outside the grid.
REQ-006 SHALL have port clk, input, 1 bit: the only clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port video_on, input, 1 bit: display-active qualifier.
REQ-009 SHALL have ports pixel_x and pixel_y, inputs, 10 bits each: current pixel coordinates.
REQ-010 SHALL have port board, input, GRID_N*GRID_N*4 bits: row-major cell values, cell (0,0) in the MSBs, 0 meaning empty.
REQ-011 SHALL have ports cur_row and cur_col, inputs, 4 bits each, plus cur_valid, input, 1 bit: cursor position and cursor enable.
REQ-012 SHALL have port status, input, 2 bits: 01 = won, 10 = lost, 00 or 11 = playing.
REQ-013 SHALL have ports r, g and b, outputs, 4 bits each, all registered.
REQ-014 SHALL have port frame_tick, output, 1 bit: registered one-clock pulse per frame.

Function
REQ-015 SHALL assert frame_tick one clock after the input sample pixel_y==481 and pixel_x==0.
REQ-016 SHALL hold a 6-bit frame counter that increments on each frame_tick and wraps 63->0.
REQ-017 SHALL use a 2-stage pipeline: rgb reflects the pixel_x/pixel_y/video_on sampled exactly 2 clocks earlier, with no stalls.
REQ-018 SHALL, in stage 1, register on_grid, cell row, cell column and in-cell offsets, computed with CELL_PX-wide arithmetic and no divider.
REQ-019 SHALL, in stage 2, select the cell value, look up a 5x7 glyph scaled x3 and centred in the cell, and compose the colour.
REQ-020 SHALL apply colour priority, highest first:
- video_on=0 -> 12'h000
- off grid -> BG_COLOR
- border pixel -> status colour (REQ-023)
- grid line -> 12'h000
- glyph pixel -> 12'h008
- cursor cell -> 12'hFF8
- otherwise -> 12'hFFF
REQ-021 SHALL draw grid lines 1 px wide at each cell boundary and 2 px wide at multiples of SUB cells and at the outer edges.
REQ-022 SHALL render cell value 0 as empty and cell values 10..15 as a solid 12'hF00 cell fill.
REQ-023 SHALL run a status FSM with states PLAY, WIN and LOSE, sampled on frame_tick only:
- status 01 -> WIN; status 10 -> LOSE; 00 or 11 -> PLAY
- WIN: the 4 px outer border alternates 12'h0F0 / 12'h000 on frame counter bit 4
- LOSE: same alternation with 12'hF00
- PLAY: border drawn as grid line
REQ-024 SHALL treat cur_row >= GRID_N or cur_col >= GRID_N as no cursor.
REQ-025 SHALL read cursor and board combinationally each cycle; changes mid-frame appear on the next affected pixel after pipeline latency.

Reset
REQ-026 SHALL, while rst is high, force r, g, b to 0, frame_tick to 0, frame counter to 0, FSM to PLAY and all pipeline registers to 0, asynchronously.
REQ-027 SHALL, after rst deasserts mid-frame, show valid pixels from the third clock onward; no frame alignment is required.

Configuration
REQ-028 SHALL support macro GRID_CURSOR_BLINK_EN:
- defined: cursor fill shown only while frame counter bit 5 = 0 (blink every 32 frames)
- undefined: cursor fill shown steadily whenever cur_valid=1 and the cursor is in range

Verification
REQ-029 SHALL check: rst=1 with any pixel inputs -> rgb=000 and frame_tick=0; release rst at pixel (0,0) -> valid rgb at clock 3.
REQ-030 SHALL check: GRID_N=9, defaults, pixel (60,40) video_on=1 -> rgb 000 two clocks later; pixel (10,10) -> EEE.
REQ-031 SHALL check: board cell (0,0)=5, cursor (0,0) valid, macro undefined -> glyph pixels 008 and remaining interior FF8.
REQ-032 SHALL check: cursor (9,2) with GRID_N=9 -> no FF8 anywhere; cell value 12 -> that cell interior F00.
REQ-033 SHALL check: status=01 held for 40 frames -> border 0F0 for frames 0-15, 000 for frames 16-31, then 0F0 again; status=00 -> PLAY at the next frame_tick.
REQ-034 SHALL check: GRID_N=4, SUB=2 -> 2 px lines at cell boundaries 0, 2 and 4, and 1 px lines at boundaries 1 and 3.
